wb_write_buffer: RTL

WB_WRITE_BUFFER -- requirements
Module: wb_write_buffer

---
 rtl/wb_write_buffer.sv | 126 ++++++++++++
 1 files changed

// File: rtl/wb_write_buffer.sv
// Four-entry write-back buffer between the pipeline and the register file.
// Optional decode-stage bypass lookup is compiled in when WB_BYPASS_EN is defined.
module wb_write_buffer (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        regWrite,
    input  logic [4:0]  rd,
    input  logic [31:0] valueToWB,
    output logic        inReady,
    output logic        wrEn,
    output logic [4:0]  wrAddr,
    output logic [31:0] wrData,
    input  logic        wrAck,
    output logic [2:0]  level,
    input  logic [4:0]  readRegister1,
    input  logic [4:0]  readRegister2,
    output logic        hit1,
    output logic        hit2,
    output logic [31:0] hitData1,
    output logic [31:0] hitData2
);

    localparam int unsigned Depth = 4;

    logic [1:0]  wr_ptr_q, wr_ptr_d;
    logic [1:0]  rd_ptr_q, rd_ptr_d;
    logic [2:0]  count_q, count_d;
    logic [4:0]  rd_mem_q   [Depth];
    logic [31:0] data_mem_q [Depth];

    logic accept;
    logic push;
    logic pop;
    logic empty;

    assign empty   = (count_q == 3'd0);
    assign inReady = (count_q != 3'(Depth));
    assign accept  = regWrite && inReady;
    // Writes to x0 are consumed but never stored.
    assign push    = accept && (rd != 5'd0);
    assign pop     = !empty && wrAck;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + 2'd1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 2'd1;
        end
        if (push && !pop) begin
            count_d = count_q + 3'd1;
        end else if (pop && !push) begin
            count_d = count_q - 3'd1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= 2'd0;
            rd_ptr_q <= 2'd0;
            count_q  <= 3'd0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: every read is qualified by count_q.
    always_ff @(posedge clk) begin
        if (push) begin
            rd_mem_q[wr_ptr_q]   <= rd;
            data_mem_q[wr_ptr_q] <= valueToWB;
        end
    end

    always_comb begin
        wrEn   = !empty;
        wrAddr = 5'd0;
        wrData = 32'd0;
        if (!empty) begin
            wrAddr = rd_mem_q[rd_ptr_q];
            wrData = data_mem_q[rd_ptr_q];
        end
    end

    assign level = count_q;

`ifdef WB_BYPASS_EN
    logic [1:0] lk_idx;

    // Scan oldest to newest so the newest matching entry wins.
    always_comb begin
        hit1     = 1'b0;
        hit2     = 1'b0;
        hitData1 = 32'd0;
        hitData2 = 32'd0;
        lk_idx   = rd_ptr_q;
        for (int i = 0; i < Depth; i++) begin
            lk_idx = rd_ptr_q + 2'(i);
            if (3'(i) < count_q) begin
                if ((readRegister1 != 5'd0) && (rd_mem_q[lk_idx] == readRegister1)) begin
                    hit1     = 1'b1;
                    hitData1 = data_mem_q[lk_idx];
                end
                if ((readRegister2 != 5'd0) && (rd_mem_q[lk_idx] == readRegister2)) begin
                    hit2     = 1'b1;
                    hitData2 = data_mem_q[lk_idx];
                end
            end
        end
    end
`else
    logic unused_lookup;

    assign unused_lookup = ^{readRegister1, readRegister2};
    assign hit1          = 1'b0;
    assign hit2          = 1'b0;
    assign hitData1      = 32'd0;
    assign hitData2      = 32'd0;
`endif

endmodule
